mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single multi-cycle data memory port between the instruction-fetch requester (I port) and the load/store requester (D port) of the MIPS core. It sequences each access against the memory's address-change-triggered delay and `mem_ready` flag, returns read data and a one-cycle acknowledge to the winning requester, and guards against a hung memory with a timeout. It sits between the IF/MEM pipeline stages and the data memory instance.

## Interface
- `ADDR_W`, 32, address width (byte address; memory indexes words with `[31:2]`)
- `DATA_W`, 32, data width
- `TIMEOUT`, 16, max WAIT cycles before forced completion; counter width `$clog2(TIMEOUT+1)`

- `clk` in 1, single clock, all state on rising edge
- `rst_n` in 1, asynchronous active-low reset
- `i_req` in 1, instruction read request; held with `i_addr` stable until `i_ack`
- `i_addr` in ADDR_W, instruction address
- `i_rdata` out DATA_W, registered read data, valid with `i_ack`, held until next I completion
- `i_ack` out 1, one-cycle completion pulse
- `d_req` in 1, data request; held with `d_we/d_addr/d_wdata` stable until `d_ack`
- `d_we` in 1, 1 = write, 0 = read
- `d_addr` in ADDR_W, data address
- `d_wdata` in DATA_W, write data
- `d_rdata` out DATA_W, registered read data, valid with `d_ack`, held until next D completion
- `d_ack` out 1, one-cycle completion pulse
- `mem_addr` out ADDR_W, registered address to memory
- `mem_write` out 1, memory write enable
- `mem_wdata` out DATA_W, memory write data
- `mem_rdata` in DATA_W, memory read data
- `mem_ready` in 1, memory ready; only 1'b1 counts as ready
- `busy` out 1, state != IDLE
- `err` out 1, sticky timeout flag, cleared only by reset

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: `req` is sampled only here. Neither → stay. One → grant it. Both → grant port not in `last_grant` (round-robin). On grant: latch port, we, wdata; load `mem_addr`; update `last_grant`; → ISSUE.
- ISSUE: exactly one cycle; `mem_ready` ignored (stale from prior access). → WAIT, timeout counter cleared.
- WAIT: `mem_ready`==1 → capture `mem_rdata` into granted port's rdata (D write: rdata unchanged), → DONE. Else counter+1; counter==TIMEOUT → set `err`, granted rdata <= 0, → DONE.
- DONE: granted port's `ack`=1 for this cycle only; → IDLE unconditionally.
- `mem_write` = 1 in ISSUE and WAIT only when grant is D and `d_we`=1; 0 in IDLE/DONE. Repeated writes of same data/address are harmless.
- `mem_addr`, `mem_wdata` hold their last value in IDLE/DONE (never change unless a new grant) so the memory does not restart its delay spuriously.
- I port never writes.
- Reset (any state, including mid-WAIT): state IDLE, `mem_addr`=0, `mem_wdata`=0, `mem_write`=0, both `ack`=0, both `rdata`=0, `err`=0, `last_grant`=I (D wins first conflict). Interrupted access is dropped, no ack.

## Timing
- Memory delay 3, new address: req sampled in IDLE cycle C; ack high in cycle C+6 (ISSUE C+1, WAIT C+2..C+5, DONE C+6).
- Same address as previous access (memory `mem_ready` stays 1): ack in cycle C+3.
- Requester sees ack and updates req at the same edge; IDLE re-samples next cycle, so back-to-back accesses cost one IDLE cycle.
- Timeout: ack at cycle C+3+TIMEOUT when `mem_ready` never rises.
- `i_ack` and `d_ack` never high together; at most one outstanding access.

## Test plan
- Single I read, `i_addr`=0x10, RAM[4]=0xDEADBEEF, delay 3 → `i_ack` pulse at C+6, `i_rdata`=0xDEADBEEF, `mem_write` never 1.
- D write 0x12345678 to 0x20 then D read 0x20 → write ack at C+6 with `mem_write` high exactly ISSUE+WAIT cycles; read returns 0x12345678.
- `i_req` and `d_req` asserted together from reset, both held → grants D, I, D, I; no cycle with both acks.
- Two consecutive I reads of 0x40 → first ack latency 6, second latency 3, same data.
- Memory `mem_ready` tied 0, TIMEOUT=16 → `d_ack` at C+19, `d_rdata`=0, `err`=1 and stays 1 across later good accesses.
- Assert `rst_n`=0 during WAIT → all outputs reset values immediately (async), no ack; after release, next conflict granted to D.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Brief    : Requester and memory-side bus bundle for the shared memory port
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction-fetch requester
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;

    // Load/store requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    // Data memory side
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    // Arbiter view
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_ack, d_rdata, d_ack, mem_addr, mem_write, mem_wdata
    );

    // Environment view: requesters plus memory
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_ack, d_rdata, d_ack, mem_addr, mem_write, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Brief    : Round-robin I/D arbiter for one multi-cycle data memory port
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus,
    output logic               busy,
    output logic               err
);

    localparam int c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]         r_state;
    logic               r_grant_d;
    logic               r_we;
    logic               r_last_d;
    logic [c_cnt_w-1:0] r_cnt;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic               r_mem_write;
    logic               r_i_ack;
    logic               r_d_ack;
    logic [DATA_W-1:0]  r_i_rdata;
    logic [DATA_W-1:0]  r_d_rdata;
    logic               r_err;

    logic               w_any_req;
    logic               w_grant_d;
    logic               w_mem_ready;

    assign w_any_req   = bus.i_req | bus.d_req;
    // On a conflict the port that did not win last time gets the grant.
    assign w_grant_d   = bus.d_req & (~bus.i_req | ~r_last_d);
    assign w_mem_ready = (bus.mem_ready == 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_grant_d   <= 1'b0;
            r_we        <= 1'b0;
            r_last_d    <= 1'b0;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_write <= 1'b0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_any_req) begin
                        r_grant_d   <= w_grant_d;
                        r_last_d    <= w_grant_d;
                        r_we        <= w_grant_d & bus.d_we;
                        r_mem_write <= w_grant_d & bus.d_we;
                        r_mem_addr  <= w_grant_d ? bus.d_addr : bus.i_addr;
                        if (w_grant_d) begin
                            r_mem_wdata <= bus.d_wdata;
                        end
                        r_state <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    // mem_ready still reflects the previous access here.
                    r_cnt   <= '0;
                    r_state <= c_st_wait;
                end
                c_st_wait: begin
                    if (w_mem_ready) begin
                        if (!r_grant_d) begin
                            r_i_rdata <= bus.mem_rdata;
                        end else if (!r_we) begin
                            r_d_rdata <= bus.mem_rdata;
                        end
                        r_mem_write <= 1'b0;
                        r_i_ack     <= ~r_grant_d;
                        r_d_ack     <= r_grant_d;
                        r_state     <= c_st_done;
                    end else if (r_cnt == c_timeout) begin
                        r_err <= 1'b1;
                        if (r_grant_d) begin
                            r_d_rdata <= '0;
                        end else begin
                            r_i_rdata <= '0;
                        end
                        r_mem_write <= 1'b0;
                        r_i_ack     <= ~r_grant_d;
                        r_d_ack     <= r_grant_d;
                        r_state     <= c_st_done;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_write = r_mem_write;
    assign bus.i_ack     = r_i_ack;
    assign bus.d_ack     = r_d_ack;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_rdata   = r_d_rdata;

    assign busy = (r_state != c_st_idle);
    assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Brief    : Directed bench with a transaction-level model of the arbiter
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int c_timeout = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    logic err;
    logic stuck = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   wr_cycles = 0;
    int   ack_log[$];

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(c_timeout)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input int idx);
        return (idx == 4) ? 32'hDEADBEEF : (32'hA500_0000 | 32'(idx));
    endfunction

    // Memory: new address drops ready for 3 cycles; stuck forces ready low.
    logic [31:0]  ram [256];
    logic [255:0] ram_wr = '0;
    logic [31:0]  m_last = '0;
    int           m_cnt = 0;
    logic         m_rdy = 1'b1;

    always @(posedge clk) begin
        if (bus.mem_write) begin
            ram[bus.mem_addr[9:2]]    <= bus.mem_wdata;
            ram_wr[bus.mem_addr[9:2]] <= 1'b1;
        end
        if (bus.mem_addr != m_last) begin
            m_last <= bus.mem_addr;
            m_cnt  <= 3;
            m_rdy  <= 1'b0;
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
        end else if (m_cnt == 1) begin
            m_cnt <= 0;
            m_rdy <= 1'b1;
        end
    end

    assign bus.mem_rdata = ram_wr[bus.mem_addr[9:2]] ? ram[bus.mem_addr[9:2]]
                                                     : init_val(int'(bus.mem_addr[9:2]));
    assign bus.mem_ready = m_rdy & ~stuck;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Transaction-level model: each grant occupies a fixed latency window.
    logic [31:0] model_mem [int];
    int          m_free, m_start, m_end, n;
    bit          m_act, m_gd, m_we, m_to, m_last_d, m_err, in_acc, done;
    logic [31:0] m_last_addr, m_exp_addr, m_exp_wdata, e_i, e_d, a;

    function automatic logic [31:0] model_val(input logic [31:0] addr);
        int idx = int'(addr[9:2]);
        return model_mem.exists(idx) ? model_mem[idx] : init_val(idx);
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            n = cyc;
            if (!rst_n) begin
                m_act = 0; m_free = 0; m_last_d = 0; m_err = 0;
                m_last_addr = '0; m_exp_addr = '0; m_exp_wdata = '0;
                e_i = '0; e_d = '0;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_ack", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
                chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
                chk("rst_mem_addr", bus.mem_addr, 32'd0);
                chk("rst_rdata", bus.i_rdata | bus.d_rdata, 32'd0);
                chk("rst_err", 32'(err), 32'd0);
            end else begin
                chk("mem_addr", bus.mem_addr, m_exp_addr);
                chk("mem_wdata", bus.mem_wdata, m_exp_wdata);
                if (n >= m_free && (bus.i_req || bus.d_req)) begin
                    m_gd     = bus.d_req && (!bus.i_req || !m_last_d);
                    m_last_d = m_gd;
                    m_we     = m_gd && bus.d_we;
                    a        = m_gd ? bus.d_addr : bus.i_addr;
                    m_to     = stuck;
                    m_start  = n;
                    m_end    = n + (stuck ? 3 + c_timeout : ((a == m_last_addr) ? 3 : 6));
                    m_free   = m_end + 1;
                    m_act    = 1;
                    m_last_addr = a;
                    m_exp_addr  = a;
                    if (m_gd) m_exp_wdata = bus.d_wdata;
                    if (m_we) model_mem[int'(a[9:2])] = bus.d_wdata;
                end
                in_acc = m_act && n > m_start && n <= m_end;
                done   = m_act && n == m_end;
                if (done) begin
                    if (m_to) begin
                        m_err = 1;
                        if (m_gd) e_d = '0; else e_i = '0;
                    end else if (!m_gd) begin
                        e_i = model_val(m_exp_addr);
                    end else if (!m_we) begin
                        e_d = model_val(m_exp_addr);
                    end
                end
                chk("busy", 32'(busy), 32'(in_acc));
                chk("i_ack", 32'(bus.i_ack), 32'(done && !m_gd));
                chk("d_ack", 32'(bus.d_ack), 32'(done && m_gd));
                chk("mem_write", 32'(bus.mem_write), 32'(in_acc && !done && m_we));
                chk("i_rdata", bus.i_rdata, e_i);
                chk("d_rdata", bus.d_rdata, e_d);
                chk("err", 32'(err), 32'(m_err));
            end
            chk("ack_exclusive", 32'(bus.i_ack && bus.d_ack), 32'd0);
            if (bus.mem_write) wr_cycles++;
            if (bus.i_ack) ack_log.push_back(0);
            if (bus.d_ack) ack_log.push_back(1);
        end
    end

    task automatic do_i(input logic [31:0] addr, output logic [31:0] data, output int lat);
        int start;
        bit ok = 0;
        bus.i_req  = 1'b1;
        bus.i_addr = addr;
        start = cyc;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.i_ack) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL i_ack_wait: got no ack, required ack within 100 cycles");
        end
        lat  = cyc - start;
        data = bus.i_rdata;
        @(posedge clk); #1;
        bus.i_req = 1'b0;
    endtask

    task automatic do_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] data, output int lat);
        int start;
        bit ok = 0;
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        start = cyc;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.d_ack) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL d_ack_wait: got no ack, required ack within 100 cycles");
        end
        lat  = cyc - start;
        data = bus.d_rdata;
        @(posedge clk); #1;
        bus.d_req = 1'b0;
    endtask

    logic [31:0] rd, rd2, rd3, rd4;
    int          lat, lat2, lat3, lat4, w0;

    initial begin
        rst_n = 1'b0;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single instruction read from a new address
        w0 = wr_cycles;
        do_i(32'h10, rd, lat);
        chk("i_read_latency", 32'(lat), 32'd6);
        chk("i_read_data", rd, 32'hDEADBEEF);
        chk("i_read_no_write", 32'(wr_cycles - w0), 32'd0);

        // Data write then read-back of the same word
        w0 = wr_cycles;
        do_d(1'b1, 32'h20, 32'h12345678, rd, lat);
        chk("d_write_latency", 32'(lat), 32'd6);
        chk("d_write_we_cycles", 32'(wr_cycles - w0), 32'd5);
        do_d(1'b0, 32'h20, 32'h0, rd, lat);
        chk("d_read_latency", 32'(lat), 32'd3);
        chk("d_read_data", rd, 32'h12345678);

        // Repeated fetch of one address: second access skips the delay
        do_i(32'h40, rd, lat);
        do_i(32'h40, rd2, lat2);
        chk("i_rep_lat1", 32'(lat), 32'd6);
        chk("i_rep_lat2", 32'(lat2), 32'd3);
        chk("i_rep_data1", rd, 32'hA500_0010);
        chk("i_rep_data2", rd2, 32'hA500_0010);

        // Both ports held: grants alternate D, I, D, I
        ack_log.delete();
        fork
            begin
                do_d(1'b0, 32'h80, 32'h0, rd, lat);
                do_d(1'b0, 32'h88, 32'h0, rd2, lat2);
            end
            begin
                do_i(32'h84, rd3, lat3);
                do_i(32'h8c, rd4, lat4);
            end
        join
        chk("rr_count", 32'(ack_log.size()), 32'd4);
        if (ack_log.size() == 4) begin
            chk("rr_order0", 32'(ack_log[0]), 32'd1);
            chk("rr_order1", 32'(ack_log[1]), 32'd0);
            chk("rr_order2", 32'(ack_log[2]), 32'd1);
            chk("rr_order3", 32'(ack_log[3]), 32'd0);
        end
        chk("rr_d_data", rd2, 32'hA500_0022);
        chk("rr_i_data", rd4, 32'hA500_0023);

        // Hung memory: forced completion, sticky error
        stuck = 1'b1;
        do_d(1'b0, 32'h100, 32'h0, rd, lat);
        stuck = 1'b0;
        chk("to_latency", 32'(lat), 32'd19);
        chk("to_rdata", rd, 32'h0);
        chk("to_err", 32'(err), 32'd1);
        do_i(32'h10, rd, lat);
        chk("post_to_data", rd, 32'hDEADBEEF);
        chk("err_sticky", 32'(err), 32'd1);

        // Asynchronous reset while waiting on memory
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h200;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_mem_addr", bus.mem_addr, 32'd0);
        chk("async_mem_write", 32'(bus.mem_write), 32'd0);
        chk("async_err", 32'(err), 32'd0);
        chk("async_i_rdata", bus.i_rdata, 32'd0);
        chk("async_ack", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
        bus.i_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ack_log.delete();
        fork
            do_d(1'b0, 32'h304, 32'h0, rd, lat);
            do_i(32'h300, rd2, lat2);
        join
        chk("post_rst_count", 32'(ack_log.size()), 32'd2);
        if (ack_log.size() == 2) begin
            chk("post_rst_first_d", 32'(ack_log[0]), 32'd1);
        end
        chk("post_rst_d_lat", 32'(lat), 32'd6);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
